// File: rtl/axi_wr_req_ctlr.sv
// Single-beat AXI4 write master: one command in, AW+W out, B back,
// completion pulse with error flag. One transaction in flight.
module axi_wr_req_ctlr #(
   parameter logic [2:0] AWSIZE = 3'h2,
   parameter logic [3:0] AWID   = 4'h0
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic [63:0]  awaddr,
   output logic [1:0]   awburst,
   output logic [3:0]   awid,
   output logic [7:0]   awlen,
   output logic [2:0]   awsize,
   output logic         awvalid,
   input  logic         awready,
   output logic         awlock,
   output logic [2:0]   awprot,
   output logic [3:0]   awqos,
   output logic [3:0]   awcache,
   output logic [127:0] wdata,
   output logic [15:0]  wstrb,
   output logic         wlast,
   output logic         wvalid,
   input  logic         wready,
   input  logic [3:0]   bid,
   input  logic [1:0]   bresp,
   input  logic         bvalid,
   output logic         bready,
   input  logic         WqValid,
   input  logic [63:0]  WqAddr,
   input  logic [127:0] WqData,
   input  logic [15:0]  WqStrb,
   output logic         WqBusy,
   output logic         WqDone,
   output logic         WqErr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state_q;
   logic [63:0]    awaddr_q;
   logic [127:0]   wdata_q;
   logic [15:0]    wstrb_q;
   logic           awvalid_q;
   logic           wvalid_q;
   logic           bready_q;
   logic           done_q;
   logic           err_q;
   logic           aw_done_q;
   logic           w_done_q;

   logic           aw_fire_d;
   logic           w_fire_d;
   logic           both_d;
   logic           unused_bid;

   // Handshake detection and "both channels finished" qualifier
   always_comb begin
      aw_fire_d = awvalid_q & awready;
      w_fire_d  = wvalid_q & wready;
      both_d    = (aw_done_q | aw_fire_d) & (w_done_q | w_fire_d);
   end

   // Transaction FSM with registered handshake and completion outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (WqValid) begin
                  awaddr_q  <= WqAddr;
                  wdata_q   <= WqData;
                  wstrb_q   <= WqStrb;
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  state_q   <= SEND;
               end
            end
            SEND: begin
               if (aw_fire_d) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (w_fire_d) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
               end
               if (both_d) begin
                  bready_q <= 1'b1;
                  state_q  <= RESP;
               end
            end
            RESP: begin
               if (bvalid && bready_q) begin
                  bready_q <= 1'b0;
                  done_q   <= 1'b1;
                  err_q    <= (bresp != 2'b00);
                  state_q  <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign unused_bid = ^bid;

   assign awaddr  = awaddr_q;
   assign awburst = 2'h1;
   assign awid    = AWID;
   assign awlen   = 8'h0;
   assign awsize  = AWSIZE;
   assign awvalid = awvalid_q;
   assign awlock  = 1'b0;
   assign awprot  = 3'h2;
   assign awqos   = 4'h0;
   assign awcache = 4'h0;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wlast   = wvalid_q;
   assign wvalid  = wvalid_q;
   assign bready  = bready_q;
   assign WqBusy  = (state_q != IDLE);
   assign WqDone  = done_q;
   assign WqErr   = err_q;

endmodule

// File: doc/axi_wr_req_ctlr.md
Name: axi_wr_req_ctlr

Overview:
- Single-beat AXI4 write master. It is the write-direction counterpart of the team's single-beat AXI read request controller.
- Accepts one write command (address, 128-bit data, byte strobes) from the PCIe DMA controller logic and drives AW and W concurrently.
- Waits for the B response, then returns a one-cycle completion pulse with an error flag.
- Exactly one outstanding transaction at a time.

Parameters:
- AWSIZE, 3'h2, value driven on awsize (beat size encoding).
- AWID, 4'h0, value driven on awid.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- awaddr  out  64  write address, registered.
- awburst  out  2  constant 2'h1 (INCR).
- awid  out  4  constant AWID.
- awlen  out  8  constant 8'h0 (single beat).
- awsize  out  3  constant AWSIZE.
- awvalid  out  1  address valid, registered.
- awready  in  1  address ready.
- awlock  out  1  constant 0.
- awprot  out  3  constant 3'h2.
- awqos  out  4  constant 0.
- awcache  out  4  constant 0.
- wdata  out  128  write data, registered.
- wstrb  out  16  byte strobes, registered.
- wlast  out  1  equals wvalid (single beat).
- wvalid  out  1  data valid, registered.
- wready  in  1  data ready.
- bid  in  4  response id, ignored.
- bresp  in  2  write response.
- bvalid  in  1  response valid.
- bready  out  1  response ready, registered.
- WqValid  in  1  write command request.
- WqAddr  in  64  command address.
- WqData  in  128  command data.
- WqStrb  in  16  command strobes.
- WqBusy  out  1  combinational, high when state != IDLE.
- WqDone  out  1  one-cycle completion pulse, registered.
- WqErr  out  1  error qualifier, valid only with WqDone, registered.

Behaviour:
- Reset (asynchronous): state=IDLE; awvalid, wvalid, bready, WqDone and WqErr are 0; awaddr, wdata and wstrb are 0; aw_done and w_done flags are 0.
- State machine:
  - IDLE: if WqValid, latch WqAddr into awaddr, WqData into wdata and WqStrb into wstrb. Set awvalid=wvalid=1 and clear both flags at the next edge. Go to SEND.
  - SEND: AW and W are handled independently.
    - On awvalid&awready: awvalid=0 next cycle and aw_done is set.
    - On wvalid&wready: wvalid=0 next cycle and w_done is set.
    - Each valid is held high until its own handshake completes; valid is never withdrawn early.
    - When both handshakes have occurred (the same cycle, or the second one completing the pair): bready=1 next cycle, go to RESP.
  - RESP: bready held at 1. On bvalid&bready: bready=0, WqDone=1 and WqErr=(bresp!=2'b00) at the next edge, go to IDLE. EXOKAY is treated as an error.
- Latency (zero-wait slave): WqValid at cycle 0 → awvalid/wvalid high at cycle 1 → bready high at cycle 2. A bvalid that is already high at cycle 2 completes the handshake, giving WqDone at cycle 3.
- WqValid is ignored while WqBusy=1. A new command may be accepted in the same cycle that WqDone is high, because the state is already IDLE.
- awaddr, wdata and wstrb hold their latched values until the next accepted command.
- Address alignment and strobe consistency are not checked; they are the requester's responsibility.
- bvalid arriving while the block is in IDLE or SEND is not consumed, because bready=0.
- A reset asserted mid-transaction abandons it immediately with no WqDone. The interconnect is assumed to be reset together with this block.

Test Plan:
- Zero-wait write:
  - Stimulus: WqAddr=0x1000, WqData=0xDEADBEEF, WqStrb=0x000F; awready, wready and bvalid held at 1; bresp=0.
  - Required: awaddr=0x1000 and wvalid at cycle 1; WqDone=1 and WqErr=0 at cycle 3; WqBusy low at cycle 3.
- Skewed handshakes:
  - Stimulus: awready delayed 4 cycles; wready immediate.
  - Required: wvalid drops at cycle 2; awvalid holds until its handshake; bready rises only after AW completes. Repeat with W delayed and AW immediate.
- Error response:
  - Stimulus: bresp=2'b10 (SLVERR), and separately bresp=2'b01 (EXOKAY).
  - Required: WqDone=1 with WqErr=1 in both cases.
- Busy rejection and back-to-back:
  - Stimulus: a second WqValid pulse during SEND, then WqValid held high continuously.
  - Required: the pulse during SEND is dropped. With WqValid held, a new command is latched on the WqDone cycle, and awvalid reasserts the following cycle.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during RESP.
  - Required: all valids and bready are 0 immediately; no WqDone; the block is IDLE and accepts a command after release.
- Constants: awlen=0, awburst=1, awprot=2, and wlast==wvalid on every cycle.
